// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, issues word fetches and buffers one instruction for decode.
// Defining FETCH_PERF_CNT_EN adds the perf_fetched / perf_stall counters.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  input  logic                  halt_req,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-3:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [INSN_WIDTH-1:0] imem_resp_data,
  output logic                  insn_valid,
  output logic [INSN_WIDTH-1:0] insn_data,
  output logic [ADDR_WIDTH-3:0] insn_pc,
  input  logic                  insn_ready,
  output logic                  halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam int PW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_RESET, S_REQ, S_WAIT, S_HALTED} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pc_q, pc_d;
  logic [PW-1:0]         req_pc_q, req_pc_d;
  logic                  kill_q, kill_d;
  logic                  pend_q, pend_d;
  logic                  buf_vld_q, buf_vld_d;
  logic [INSN_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [PW-1:0]         buf_pc_q, buf_pc_d;
  logic                  buf_free, req_vld, req_hs;

  // pend_q keeps an offered but not yet accepted request stable even if halt_req rises.
  assign buf_free = !buf_vld_q || insn_ready;
  assign req_vld  = (state_q == S_REQ) && (pend_q || (buf_free && !halt_req));
  assign req_hs   = req_vld && imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    pend_d     = pend_q;
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    if (buf_vld_q && insn_ready) buf_vld_d = 1'b0;

    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          pend_d   = 1'b0;
          state_d  = S_WAIT;
        end else if (req_vld) begin
          pend_d = 1'b1;
        end
        if (redirect_valid) begin
          pc_d      = redirect_addr;
          buf_vld_d = 1'b0;
          pend_d    = 1'b0;
          kill_d    = req_hs;
        end else if (req_hs) begin
          pc_d = pc_q + PW'(1);
        end else if (!req_vld && halt_req) begin
          state_d = S_HALTED;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          kill_d  = 1'b0;
          state_d = (halt_req && !redirect_valid) ? S_HALTED : S_REQ;
          if (!kill_q && !redirect_valid) begin
            buf_vld_d  = 1'b1;
            buf_data_d = imem_resp_data;
            buf_pc_d   = req_pc_q;
          end
        end
        // A redirect with no response yet leaves a stale response in flight; mark it for dropping.
        if (redirect_valid) begin
          pc_d      = redirect_addr;
          buf_vld_d = 1'b0;
          if (!imem_resp_valid) kill_d = 1'b1;
        end
      end
      S_HALTED: begin
        if (redirect_valid) begin
          pc_d      = redirect_addr;
          buf_vld_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      pc_q       <= rst_addr;
      kill_q     <= 1'b0;
      pend_q     <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
      buf_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      pend_q     <= pend_d;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  assign imem_req_valid = req_vld;
  assign imem_req_addr  = pc_q;
  assign insn_valid     = buf_vld_q;
  assign insn_data      = buf_data_q;
  assign insn_pc        = buf_pc_q;
  assign halted         = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (buf_vld_q && insn_ready) perf_fetched_q <= perf_fetched_q + 32'd1;
      if ((state_q == S_REQ) && ((req_vld && !imem_req_ready) || (!req_vld && !buf_free)))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

`ifndef SYNTHESIS
  a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (state_q == S_WAIT));
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a randomized run against a
// program-order model (expected request / delivery addresses and a memory content function).
module tb_fetch_sequencer;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int PW = AW - 2;

  logic          clk;
  logic          rst;
  logic [PW-1:0] rst_addr;
  logic          redirect_valid;
  logic [PW-1:0] redirect_addr;
  logic          halt_req;
  logic          imem_req_valid;
  logic [PW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_data;
  logic          insn_valid;
  logic [IW-1:0] insn_data;
  logic [PW-1:0] insn_pc;
  logic          insn_ready;
  logic          halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
`endif

  int pass_cnt  = 0;
  int tot_cnt   = 0;
  int fail_cnt  = 0;
  int mem_lat   = 1;  // 0 selects a random latency of 1..3 cycles
  int delivered = 0;

  fetch_sequencer #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rst_addr        (rst_addr),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .halt_req        (halt_req),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .insn_valid      (insn_valid),
    .insn_data       (insn_data),
    .insn_pc         (insn_pc),
    .insn_ready      (insn_ready),
    .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [IW-1:0] memf(input logic [PW-1:0] a);
    return ({a, 2'b00} * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tot_cnt++;
    assert (obs === want) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(imem_req_valid), 64'h1);
  endtask

  task automatic wait_insn(input string tag);
    int n = 0;
    while (!insn_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(insn_valid), 64'h1);
  endtask

  // Instruction memory plus program-order scoreboard.
  initial begin : monitor
    logic [PW-1:0] exp_req, exp_del, mem_addr, stall_addr;
    logic          mem_busy, stall_prev;
    int            mem_cnt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    exp_req = '0; exp_del = '0; mem_addr = '0; stall_addr = '0;
    mem_busy = 1'b0; stall_prev = 1'b0; mem_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_req    = rst_addr;
        exp_del    = rst_addr;
        mem_busy   = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (imem_resp_valid) mem_busy = 1'b0;
        if (insn_valid && insn_ready) begin
          chk("deliver_pc", 64'(insn_pc), 64'(exp_del));
          chk("deliver_data", 64'(insn_data), 64'(memf(insn_pc)));
          exp_del = insn_pc + PW'(1);
          delivered++;
        end
        if (stall_prev) begin
          chk("stall_hold_valid", 64'(imem_req_valid), 64'h1);
          chk("stall_hold_addr", 64'(imem_req_addr), 64'(stall_addr));
        end
        if (halted) chk("halted_no_req", 64'(imem_req_valid), 64'h0);
        if (imem_req_valid && imem_req_ready) begin
          chk("one_outstanding", 64'(mem_busy), 64'h0);
          chk("req_addr", 64'(imem_req_addr), 64'(exp_req));
          mem_busy = 1'b1;
          mem_addr = imem_req_addr;
          mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
          exp_req  = exp_req + PW'(1);
        end
        stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid;
        stall_addr = imem_req_addr;
        if (redirect_valid) begin
          exp_req = redirect_addr;
          exp_del = redirect_addr;
        end
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = memf(mem_addr);
        end
        mem_cnt--;
      end
    end
  end

  initial begin : stim
    rst            = 1'b1;
    rst_addr       = 30'h400;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    halt_req       = 1'b0;
    imem_req_ready = 1'b1;
    insn_ready     = 1'b1;
    repeat (3) step();
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_insn_valid", 64'(insn_valid), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    chk("rst_insn_pc", 64'(insn_pc), 64'h0);
    chk("rst_insn_data", 64'(insn_data), 64'h0);

    // Basic sequencing from the reset vector.
    rst = 1'b0;
    #1;
    chk("t1_no_req_in_reset_cycle", 64'(imem_req_valid), 64'h0);
    step();
    chk("t1_first_req_valid", 64'(imem_req_valid), 64'h1);
    chk("t1_first_req_addr", 64'(imem_req_addr), 64'h400);
    step();
    chk("t1_wait_no_req", 64'(imem_req_valid), 64'h0);
    imem_req_ready = 1'b0;
    step();
    chk("t1_insn_valid", 64'(insn_valid), 64'h1);
    chk("t1_insn_pc", 64'(insn_pc), 64'h400);
    chk("t1_insn_data", 64'(insn_data), 64'(memf(30'h400)));

    // Memory back-pressure on 0x401.
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 64'(imem_req_valid), 64'h1);
      chk("t2_stall_addr", 64'(imem_req_addr), 64'h401);
      if (i == 4) imem_req_ready = 1'b1;
      step();
    end
    chk("t2_wait_after_hs", 64'(imem_req_valid), 64'h0);
    step();
    chk("t2_insn_pc", 64'(insn_pc), 64'h401);
    chk("t2_next_req_addr", 64'(imem_req_addr), 64'h402);
    mem_lat = 3;

    // Redirect while 0x402 is outstanding.
    step();
    chk("t3_wait_no_req", 64'(imem_req_valid), 64'h0);
    redirect_valid = 1'b1;
    redirect_addr  = 30'h800;
    step();
    redirect_valid = 1'b0;
    chk("t3_flushed", 64'(insn_valid), 64'h0);
    wait_req("t3_req_after_kill");
    chk("t3_req_addr", 64'(imem_req_addr), 64'h800);
    chk("t3_stale_dropped", 64'(insn_valid), 64'h0);
    mem_lat    = 1;
    insn_ready = 1'b0;
    wait_insn("t3_insn_arrives");
    chk("t3_insn_pc", 64'(insn_pc), 64'h800);

    // Decode back-pressure with a full buffer.
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_req_buf_full", 64'(imem_req_valid), 64'h0);
      chk("t4_buf_held_pc", 64'(insn_pc), 64'h800);
      chk("t4_buf_held_data", 64'(insn_data), 64'(memf(30'h800)));
      step();
    end
    insn_ready = 1'b1;
    #1;
    chk("t4_resume_valid", 64'(imem_req_valid), 64'h1);
    chk("t4_resume_addr", 64'(imem_req_addr), 64'h801);
    mem_lat = 3;

    // Halt while waiting, then redirect out of HALTED.
    step();
    chk("t5_wait_no_req", 64'(imem_req_valid), 64'h0);
    halt_req = 1'b1;
    wait_insn("t5_outstanding_delivered");
    chk("t5_insn_pc", 64'(insn_pc), 64'h801);
    chk("t5_halted", 64'(halted), 64'h1);
    halt_req = 1'b0;
    repeat (3) begin
      step();
      chk("t5_stays_halted", 64'(halted), 64'h1);
    end
    redirect_valid = 1'b1;
    redirect_addr  = 30'h10;
    step();
    redirect_valid = 1'b0;
    chk("t5_unhalted", 64'(halted), 64'h0);
    chk("t5_req_valid", 64'(imem_req_valid), 64'h1);
    chk("t5_req_addr", 64'(imem_req_addr), 64'h10);

    // Redirect coinciding with a handshake, then PC wrap.
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_addr  = 30'h3FFFFFFF;
    step();
    redirect_valid = 1'b0;
    chk("t6_killed_wait", 64'(imem_req_valid), 64'h0);
    wait_req("t6_req_top");
    chk("t6_req_top_addr", 64'(imem_req_addr), 64'h3FFFFFFF);
    step();
    wait_req("t6_req_wrap");
    chk("t6_wrap_addr", 64'(imem_req_addr), 64'h0);
    chk("t6_insn_top_pc", 64'(insn_pc), 64'h3FFFFFFF);

    // Randomized traffic, checked by the scoreboard.
    mem_lat = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      insn_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0) || (halted && ($urandom_range(0, 3) == 0));
      redirect_addr  = ($urandom_range(0, 3) == 0) ? (30'h3FFFFFFE + 30'($urandom_range(0, 3)))
                                                   : 30'($urandom);
      halt_req       = ($urandom_range(0, 49) == 0) || (halt_req && ($urandom_range(0, 3) != 0));
      step();
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    insn_ready     = 1'b1;
    repeat (5) step();
    chk("random_progress", 64'(delivered > 100), 64'h1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
